regfile_mp: RTL

- Next-generation general-purpose register file for the npc core.
- Parametrised width, depth and read-port count; two write ports.
- Adds a per-register busy scoreboard and a sequential post-reset clear engine.
- Sits between decode (read/reserve) and writeback (write/release).
- Register 0 is hardwired to zero.

---
 rtl/regfile_mp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with per-register busy scoreboard and post-reset clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_req,
  output logic                         ready,
  input  logic                         wen0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         wen1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   clr_idx, clr_idx_nx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]        busy, busy_nx;
  logic                    run;
  logic                    we0, we1;

  assign run   = (state == RUN);
  assign ready = run;
  assign we0   = run && wen0 && (waddr0 != '0);
  assign we1   = run && wen1 && (waddr1 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= IDX_FIRST;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    case (state)
      CLEAR: begin
        if (clr_req) begin
          clr_idx_nx = IDX_FIRST;
        end else if (clr_idx == IDX_LAST) begin
          state_nx = RUN;
        end else begin
          clr_idx_nx = clr_idx + IDX_FIRST;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_idx_nx = IDX_FIRST;
        end
      end
      default: begin
        state_nx   = CLEAR;
        clr_idx_nx = IDX_FIRST;
      end
    endcase
  end

  // Array has no reset; while not running the clear engine owns the write port.
  // Port 1 is written last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
    end
  end

  always_comb begin
    busy_nx = busy;
    if (we0) busy_nx[waddr0] = 1'b0;
    if (we1) busy_nx[waddr1] = 1'b0;
    if (run && rsv_en && (rsv_addr != '0)) busy_nx[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (run) begin
      busy <= clr_req ? '0 : busy_nx;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = mem[ra];
      rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
      // A forwarded value is already produced, so it is only busy again if re-reserved now.
      if (we1 && (waddr1 == ra)) begin
        rd = wdata1;
        rb = rsv_en && (rsv_addr == ra);
      end else if (we0 && (waddr0 == ra)) begin
        rd = wdata0;
        rb = rsv_en && (rsv_addr == ra);
      end
`endif
      if (!run || (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[k]                          = rb;
  end

endmodule
